uart_echo_checker: RTL and testbench

- Host-side initiator for the UART echo loop: drives the byte interface of a uart_tx instance, watches a uart_rx instance, and verifies that every transmitted byte returns unchanged.
- Sends NUM_BYTES bytes from an incrementing pattern, one at a time, and compares each echo.
- Counts mismatches and timeouts, and flags pass or fail at the end.
- Used for board bring-up and self-test of a UART echo target at 104 clocks per bit on the 12 MHz hwclk.

---
 rtl/uart_echo_checker.sv | 150 +++++++++++++++
 tb/tb_uart_echo_checker.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_checker.sv
// UART echo loop checker: sends an incrementing byte pattern through uart_tx,
// waits for each byte to come back on uart_rx and counts mismatches and timeouts.
module uart_echo_checker #(
  parameter int unsigned NUM_BYTES    = 16,
  parameter logic [7:0]  SEED         = 8'h41,
  parameter int unsigned TIMEOUT_CLKS = 12000
) (
  input  logic       i_hwclk,
  input  logic       i_rst,
  input  logic       i_start,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_busy,
  output logic       o_pass,
  output logic       o_fail,
  output logic [7:0] o_err_count,
  output logic [7:0] o_byte_idx
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]    LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitTx,
    StWaitEcho,
    StNext,
    StDone
  } state_e;

  state_e        r_state;
  logic          r_tx_dv;
  logic [7:0]    r_tx_byte;
  logic          r_busy;
  logic          r_pass;
  logic          r_fail;
  logic [7:0]    r_err_count;
  logic [7:0]    r_byte_idx;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_echo_got;
  logic [7:0]    r_echo_byte;

  logic          w_echo_now;
  logic [7:0]    w_echo_val;
  logic          w_mismatch;
  logic          w_tmo_hit;
  logic [7:0]    w_err_inc;
  logic [7:0]    w_pattern;
  logic          w_in_echo;

  // Echo selection: a latched echo takes precedence over one arriving this cycle.
  always_comb begin
    w_echo_now = r_echo_got | i_rx_dv;
    w_echo_val = r_echo_got ? r_echo_byte : i_rx_byte;
    w_mismatch = (w_echo_val != r_tx_byte);
    w_tmo_hit  = (r_tmo_cnt == TMO_LAST);
    w_err_inc  = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;
    w_pattern  = SEED + r_byte_idx;
    w_in_echo  = (r_state == StWaitEcho);
  end

  // Main sequencer: one byte in flight at a time, all outputs registered.
  always_ff @(posedge i_hwclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_busy      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_err_count <= 8'h00;
      r_byte_idx  <= 8'h00;
      r_tmo_cnt   <= '0;
      r_echo_got  <= 1'b0;
      r_echo_byte <= 8'h00;
    end else begin
      r_tx_dv <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_err_count <= 8'h00;
            r_byte_idx  <= 8'h00;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_echo_got  <= 1'b0;
            r_state     <= StSend;
          end
        end
        StSend: begin
          // Hold off while the transmitter is still shifting a previous byte.
          if (!i_tx_active) begin
            r_tx_dv   <= 1'b1;
            r_tx_byte <= w_pattern;
            r_tmo_cnt <= '0;
            r_state   <= StWaitTx;
          end
        end
        StWaitTx, StWaitEcho: begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
          // Only the first echo per byte is kept; duplicates are dropped.
          if (i_rx_dv && !r_echo_got) begin
            r_echo_got  <= 1'b1;
            r_echo_byte <= i_rx_byte;
          end
          // An echo present at the timeout cycle is compared rather than counted as lost.
          if ((w_in_echo || w_tmo_hit) && w_echo_now) begin
            if (w_mismatch) begin
              r_err_count <= w_err_inc;
            end
            r_state <= StNext;
          end else if (w_tmo_hit) begin
            r_err_count <= w_err_inc;
            r_state     <= StNext;
          end else if (!w_in_echo && i_tx_done) begin
            r_state <= StWaitEcho;
          end
        end
        StNext: begin
          r_echo_got <= 1'b0;
          if (r_byte_idx == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_pass  <= (r_err_count == 8'h00);
            r_fail  <= (r_err_count != 8'h00);
            r_state <= StDone;
          end else begin
            r_byte_idx <= r_byte_idx + 8'd1;
            r_state    <= StSend;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_tx_dv     = r_tx_dv;
  assign o_tx_byte   = r_tx_byte;
  assign o_busy      = r_busy;
  assign o_pass      = r_pass;
  assign o_fail      = r_fail;
  assign o_err_count = r_err_count;
  assign o_byte_idx  = r_byte_idx;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: a behavioural uart_tx/uart_rx echo model feeds the
// checker, expected bytes and run results are queued when a run is launched and a
// negedge monitor pops and compares them as the DUT produces tx_dv pulses and ends runs.
module tb_uart_echo_checker;

  localparam int unsigned TMO      = 1000;
  localparam int          ECHO_DLY = 300;
  localparam int          TXD      = 100;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] idx;
    int         gap;
  } tx_exp_t;

  typedef struct packed {
    logic [7:0] err;
    logic       pass;
    logic       fail;
  } res_exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic       tx_active = 1'b0;
  logic       tx_done = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       sel = 1'b0;

  logic       d1_tx_dv, d1_busy, d1_pass, d1_fail;
  logic [7:0] d1_tx_byte, d1_err, d1_idx;
  logic       d2_tx_dv, d2_busy, d2_pass, d2_fail;
  logic [7:0] d2_tx_byte, d2_err, d2_idx;

  logic       m_tx_dv, m_busy, m_pass, m_fail;
  logic [7:0] m_tx_byte, m_err, m_idx;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;

  tx_exp_t  q_tx[$];
  res_exp_t q_res[$];

  // Echo model controls
  int m_cnt = 0;
  int corrupt_idx = -1;
  int drop_idx = -1;
  int hold_idx = -1;
  bit dup_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_echo_checker #(
    .NUM_BYTES   (16),
    .SEED        (8'h41),
    .TIMEOUT_CLKS(TMO)
  ) u_dut1 (
    .i_hwclk    (clk),
    .i_rst      (rst),
    .i_start    (start1),
    .o_tx_dv    (d1_tx_dv),
    .o_tx_byte  (d1_tx_byte),
    .i_tx_active(tx_active),
    .i_tx_done  (tx_done),
    .i_rx_dv    (rx_dv),
    .i_rx_byte  (rx_byte),
    .o_busy     (d1_busy),
    .o_pass     (d1_pass),
    .o_fail     (d1_fail),
    .o_err_count(d1_err),
    .o_byte_idx (d1_idx)
  );

  uart_echo_checker #(
    .NUM_BYTES   (4),
    .SEED        (8'hFE),
    .TIMEOUT_CLKS(TMO)
  ) u_dut2 (
    .i_hwclk    (clk),
    .i_rst      (rst),
    .i_start    (start2),
    .o_tx_dv    (d2_tx_dv),
    .o_tx_byte  (d2_tx_byte),
    .i_tx_active(tx_active),
    .i_tx_done  (tx_done),
    .i_rx_dv    (rx_dv),
    .i_rx_byte  (rx_byte),
    .o_busy     (d2_busy),
    .o_pass     (d2_pass),
    .o_fail     (d2_fail),
    .o_err_count(d2_err),
    .o_byte_idx (d2_idx)
  );

  assign m_tx_dv   = sel ? d2_tx_dv   : d1_tx_dv;
  assign m_tx_byte = sel ? d2_tx_byte : d1_tx_byte;
  assign m_busy    = sel ? d2_busy    : d1_busy;
  assign m_pass    = sel ? d2_pass    : d1_pass;
  assign m_fail    = sel ? d2_fail    : d1_fail;
  assign m_err     = sel ? d2_err     : d1_err;
  assign m_idx     = sel ? d2_idx     : d1_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycles between consecutive tx_dv pulses, derived from the echo model timing.
  function automatic int exp_gap(input int prev);
    if (prev == drop_idx) return TMO + 2;
    if (prev == hold_idx - 1) return ECHO_DLY + 51;
    if (dup_on) return 309;
    return ECHO_DLY + 3;
  endfunction

  // Behavioural uart_tx + echo target + uart_rx.
  initial begin : echo_model
    logic [7:0] eb;
    int cur, txd, last;
    forever begin
      @(posedge clk); #1;
      if (m_tx_dv && !rst) begin
        cur = m_cnt;
        m_cnt++;
        eb = (cur == corrupt_idx) ? 8'h00 : m_tx_byte;
        txd = dup_on ? 305 : TXD;
        last = (cur == hold_idx - 1) ? ECHO_DLY + 50 : (dup_on ? 306 : ECHO_DLY + 1);
        for (int k = 1; k <= last; k++) begin
          @(posedge clk); #1;
          tx_active = (k < txd) ||
                      ((cur == hold_idx - 1) && (k >= ECHO_DLY) && (k < ECHO_DLY + 50));
          tx_done = (k == txd);
          rx_dv = 1'b0;
          if ((cur != drop_idx) && (k == ECHO_DLY)) begin
            rx_dv = 1'b1;
            rx_byte = eb;
          end
          if (dup_on && (k == ECHO_DLY + 2)) begin
            rx_dv = 1'b1;
            rx_byte = 8'hEE;
          end
        end
        tx_active = 1'b0;
        tx_done = 1'b0;
        rx_dv = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT pulses tx_dv or finishes a run.
  initial begin : monitor
    logic prev_busy;
    int unsigned last_dv;
    tx_exp_t  e;
    res_exp_t r;
    prev_busy = 1'b0;
    last_dv = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_tx_dv) begin
          if (q_tx.size() == 0) begin
            chk("unexpected_tx_dv", {24'h0, m_tx_byte}, 32'hFFFF_FFFF);
          end else begin
            e = q_tx.pop_front();
            chk("tx_byte", {24'h0, m_tx_byte}, {24'h0, e.b});
            chk("byte_idx", {24'h0, m_idx}, {24'h0, e.idx});
            chk("tx_dv_while_active", {31'h0, tx_active}, 32'h0);
            if (e.gap != 0) chk("tx_dv_gap", cyc - last_dv, e.gap);
          end
          last_dv = cyc;
        end
        if (prev_busy && !m_busy) begin
          if (q_res.size() == 0) begin
            chk("unexpected_done", {24'h0, m_err}, 32'hFFFF_FFFF);
          end else begin
            r = q_res.pop_front();
            chk("err_count", {24'h0, m_err}, {24'h0, r.err});
            chk("pass", {31'h0, m_pass}, {31'h0, r.pass});
            chk("fail", {31'h0, m_fail}, {31'h0, r.fail});
            chk("all_bytes_sent", q_tx.size(), 0);
          end
        end
      end
      prev_busy = m_busy;
    end
  end

  task automatic expect_run(input logic [7:0] seed, input int n, input int err);
    tx_exp_t e;
    res_exp_t r;
    logic [7:0] b;
    b = seed;
    for (int i = 0; i < n; i++) begin
      e.b = b;
      e.idx = 8'(i);
      e.gap = (i == 0) ? 0 : exp_gap(i - 1);
      q_tx.push_back(e);
      b = b + 8'd1;
    end
    r.err = 8'(err);
    r.pass = (err == 0);
    r.fail = (err != 0);
    q_res.push_back(r);
    m_cnt = 0;
  endtask

  task automatic kick();
    @(posedge clk); #1;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    chk("busy_after_start", {31'h0, m_busy}, 32'h1);
  endtask

  task automatic wait_idle(input int limit);
    for (int c = 0; c < limit && m_busy; c++) begin
      @(posedge clk); #1;
    end
    chk("run_finished", {31'h0, m_busy}, 32'h0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_dv"}, {31'h0, d1_tx_dv}, 32'h0);
    chk({tag, "_tx_byte"}, {24'h0, d1_tx_byte}, 32'h0);
    chk({tag, "_busy"}, {31'h0, d1_busy}, 32'h0);
    chk({tag, "_pass"}, {31'h0, d1_pass}, 32'h0);
    chk({tag, "_fail"}, {31'h0, d1_fail}, 32'h0);
    chk({tag, "_err"}, {24'h0, d1_err}, 32'h0);
    chk({tag, "_idx"}, {24'h0, d1_idx}, 32'h0);
  endtask

  initial begin : stim
    bit seen;
    #2 rst = 1'b1;
    #1 chk_reset_vals("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Ideal echo
    expect_run(8'h41, 16, 0);
    kick();
    wait_idle(20000);

    // Corrupted echo on byte 3
    corrupt_idx = 3;
    expect_run(8'h41, 16, 1);
    kick();
    wait_idle(20000);
    corrupt_idx = -1;

    // Dropped echo on byte 5
    drop_idx = 5;
    expect_run(8'h41, 16, 1);
    kick();
    wait_idle(20000);
    drop_idx = -1;

    // Reset in WAIT_ECHO of byte 7
    expect_run(8'h41, 16, 0);
    kick();
    seen = 1'b0;
    for (int c = 0; c < 8000 && !seen; c++) begin
      @(posedge clk); #1;
      seen = m_tx_dv && (m_idx == 8'd7);
    end
    chk("reached_byte7", {31'h0, seen}, 32'h1);
    repeat (150) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_vals("midrun_reset");
    q_tx.delete();
    q_res.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (400) @(posedge clk);
    #1 chk("idle_after_reset", {31'h0, d1_busy}, 32'h0);

    // Restart: tx_active hold at SEND of byte 2, duplicate echoes, ignored start
    hold_idx = 2;
    dup_on = 1'b1;
    expect_run(8'h41, 16, 0);
    kick();
    seen = 1'b0;
    for (int c = 0; c < 8000 && !seen; c++) begin
      @(posedge clk); #1;
      seen = m_tx_dv && (m_idx == 8'd4);
    end
    chk("reached_byte4", {31'h0, seen}, 32'h1);
    repeat (20) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    wait_idle(20000);
    hold_idx = -1;
    dup_on = 1'b0;

    // Pattern wrap on the second instance
    sel = 1'b1;
    repeat (2) @(posedge clk);
    expect_run(8'hFE, 4, 0);
    kick();
    wait_idle(6000);

    chk("tx_queue_drained", q_tx.size(), 0);
    chk("res_queue_drained", q_res.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
